// File: rtl/cnt_ctrl.sv
// Timer counter control: prescaled count-enable generation with
// enable, debug halt/acknowledge and illegal-divisor detection.
module cnt_ctrl #(
   parameter int DIV_W   = 4,
   parameter int MAX_DIV = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             timer_en,
   input  logic             div_en,
   input  logic [DIV_W-1:0] div_val,
   input  logic             halt_req,
   input  logic             dbg_mode,
   input  logic             cnt_clr,
   output logic             cnt_en,
   output logic             halt_ack,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [MAX_DIV-1:0]   pcnt;
   logic [MAX_DIV-1:0]   limit;
   logic                 div_en_q;
   logic [DIV_W-1:0]     div_val_q;
   logic                 halt_c;
   logic                 cfg_chg;
   logic                 cfg_bad;
   logic                 stay_run;

   localparam logic [MAX_DIV-1:0] ONE = MAX_DIV'(1);
   localparam logic [DIV_W-1:0]   DMAX = DIV_W'(MAX_DIV);

   always_comb begin
      halt_c  = dbg_mode & halt_req;
      cfg_bad = div_en & (div_val > DMAX);
      cfg_chg = (div_en != div_en_q) | (div_val != div_val_q);
      limit   = '0;
      if (div_en) begin
         limit = (ONE << div_val) - ONE;
      end
      state_nxt = RUN;
      if (!timer_en) begin
         state_nxt = IDLE;
      end else if (halt_c) begin
         state_nxt = HALT;
      end
      stay_run = (state == RUN) & (state_nxt == RUN);
   end

   // pcnt only advances while remaining in RUN; halts hold it in place
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         pcnt      <= '0;
         cnt_en    <= 1'b0;
         halt_ack  <= 1'b0;
         cfg_err   <= 1'b0;
         div_en_q  <= 1'b0;
         div_val_q <= '0;
      end else begin
         state     <= state_nxt;
         halt_ack  <= (state_nxt == HALT);
         cfg_err   <= cfg_bad;
         div_en_q  <= div_en;
         div_val_q <= div_val;
         cnt_en    <= 1'b0;
         if ((state == IDLE) || (state_nxt == IDLE)) begin
            pcnt <= '0;
         end else if (stay_run) begin
            if (cnt_clr || cfg_chg || cfg_err) begin
               pcnt <= '0;
            end else if (pcnt == limit) begin
               pcnt   <= '0;
               cnt_en <= 1'b1;
            end else begin
               pcnt <= pcnt + ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed vector bench for cnt_ctrl.
module tb_cnt_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       timer_en;
   logic       div_en;
   logic [3:0] div_val;
   logic       halt_req;
   logic       dbg_mode;
   logic       cnt_clr;
   logic       cnt_en;
   logic       halt_ack;
   logic       cfg_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       ten;
      logic       den;
      logic [3:0] dv;
      logic       hreq;
      logic       dbg;
      logic       clr;
      logic       e_cnt;
      logic       e_ack;
      logic       e_err;
   } vec_t;

   vec_t tbl[$];

   cnt_ctrl #(.DIV_W(4), .MAX_DIV(8)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .timer_en (timer_en),
      .div_en   (div_en),
      .div_val  (div_val),
      .halt_req (halt_req),
      .dbg_mode (dbg_mode),
      .cnt_clr  (cnt_clr),
      .cnt_en   (cnt_en),
      .halt_ack (halt_ack),
      .cfg_err  (cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic vec_t mk(
      input logic ten, input logic den, input logic [3:0] dv,
      input logic hreq, input logic dbg, input logic clr,
      input logic ec, input logic ea, input logic ee);
      vec_t v;
      v.ten = ten; v.den = den; v.dv = dv;
      v.hreq = hreq; v.dbg = dbg; v.clr = clr;
      v.e_cnt = ec; v.e_ack = ea; v.e_err = ee;
      return v;
   endfunction

   task automatic add(
      input int n,
      input logic ten, input logic den, input logic [3:0] dv,
      input logic hreq, input logic dbg, input logic clr,
      input logic ec, input logic ea, input logic ee);
      for (int i = 0; i < n; i++) begin
         tbl.push_back(mk(ten, den, dv, hreq, dbg, clr, ec, ea, ee));
      end
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      timer_en = v.ten;
      div_en   = v.den;
      div_val  = v.dv;
      halt_req = v.hreq;
      dbg_mode = v.dbg;
      cnt_clr  = v.clr;
      @(posedge sys_clk);
      #1;
      check({tag, " cnt_en"}, cnt_en, v.e_cnt);
      check({tag, " halt_ack"}, halt_ack, v.e_ack);
      check({tag, " cfg_err"}, cfg_err, v.e_err);
   endtask

   initial begin
      sys_rst  = 1'b1;
      timer_en = 1'b0;
      div_en   = 1'b0;
      div_val  = 4'd0;
      halt_req = 1'b0;
      dbg_mode = 1'b0;
      cnt_clr  = 1'b0;
      #12;
      check("reset cnt_en", cnt_en, 1'b0);
      check("reset halt_ack", halt_ack, 1'b0);
      check("reset cfg_err", cfg_err, 1'b0);
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // undivided run
      add(1, 1,0,0, 0,0,0, 0,0,0);
      add(4, 1,0,0, 0,0,0, 1,0,0);
      // divide by 8 from enable
      add(1, 0,1,3, 0,0,0, 0,0,0);
      add(8, 1,1,3, 0,0,0, 0,0,0);
      add(1, 1,1,3, 0,0,0, 1,0,0);
      add(7, 1,1,3, 0,0,0, 0,0,0);
      add(1, 1,1,3, 0,0,0, 1,0,0);
      // halt at pcnt=2, divide by 4
      add(3, 1,1,2, 0,0,0, 0,0,0);
      add(5, 1,1,2, 1,1,0, 0,1,0);
      add(2, 1,1,2, 0,1,0, 0,0,0);
      add(1, 1,1,2, 0,1,0, 1,0,0);
      add(3, 1,1,2, 0,1,0, 0,0,0);
      add(1, 1,1,2, 0,1,0, 1,0,0);
      // halt ignored outside debug mode
      add(2, 1,1,2, 0,0,0, 0,0,0);
      add(1, 1,1,2, 1,0,0, 0,0,0);
      add(1, 1,1,2, 1,0,0, 1,0,0);
      add(3, 1,1,2, 1,0,0, 0,0,0);
      add(1, 1,1,2, 0,0,0, 1,0,0);
      // clear on the pulse edge, then 3->1 change mid-period
      add(8, 1,1,3, 0,0,0, 0,0,0);
      add(1, 1,1,3, 0,0,1, 0,0,0);
      add(7, 1,1,3, 0,0,0, 0,0,0);
      add(1, 1,1,3, 0,0,0, 1,0,0);
      add(3, 1,1,3, 0,0,0, 0,0,0);
      add(2, 1,1,1, 0,0,0, 0,0,0);
      add(1, 1,1,1, 0,0,0, 1,0,0);
      add(1, 1,1,1, 0,0,0, 0,0,0);
      add(1, 1,1,1, 0,0,0, 1,0,0);
      // illegal divisor then restore to 16
      add(3, 1,1,9, 0,0,0, 0,0,1);
      add(16, 1,1,4, 0,0,0, 0,0,0);
      add(1, 1,1,4, 0,0,0, 1,0,0);
      // disable while halted; cfg_err in IDLE
      add(2, 1,1,4, 1,1,0, 0,1,0);
      add(1, 0,1,4, 1,1,0, 0,0,0);
      add(1, 0,0,9, 0,0,0, 0,0,0);
      add(1, 0,1,9, 0,0,0, 0,0,1);
      add(1, 0,0,0, 0,0,0, 0,0,0);
      // halt beats clear: pcnt held at 2
      add(3, 1,1,2, 0,0,0, 0,0,0);
      add(1, 1,1,2, 1,1,1, 0,1,0);
      add(2, 1,1,2, 0,0,0, 0,0,0);
      add(1, 1,1,2, 0,0,0, 1,0,0);
      // undivided clear
      add(1, 1,0,0, 0,0,0, 0,0,0);
      add(2, 1,0,0, 0,0,0, 1,0,0);
      add(1, 1,0,0, 0,0,1, 0,0,0);
      add(2, 1,0,0, 0,0,0, 1,0,0);

      foreach (tbl[i]) begin
         step(tbl[i], $sformatf("row%0d", i));
      end

      // asynchronous reset while cnt_en is high
      #2;
      sys_rst = 1'b1;
      #1;
      check("async rst cnt_en", cnt_en, 1'b0);
      @(posedge sys_clk);
      #3;
      sys_rst = 1'b0;
      step(mk(1,1,1, 0,0,0, 0,0,0), "post-rst k");
      step(mk(1,1,1, 0,0,0, 0,0,0), "post-rst k+1");
      step(mk(1,1,1, 0,0,0, 1,0,0), "post-rst k+2");
      step(mk(1,1,1, 0,0,0, 0,0,0), "post-rst k+3");
      step(mk(1,1,1, 0,0,0, 1,0,0), "post-rst k+4");

      // asynchronous reset while halted with a config error
      step(mk(1,1,9, 1,1,0, 0,1,1), "halt err");
      #2;
      sys_rst = 1'b1;
      #1;
      check("async rst halt_ack", halt_ack, 1'b0);
      check("async rst cfg_err", cfg_err, 1'b0);
      @(posedge sys_clk);
      #3;
      sys_rst = 1'b0;
      step(mk(0,0,0, 0,0,0, 0,0,0), "idle after rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
